// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared encodings for the Mini SRC hardwired controller: the
//            sequencer state enum, instruction opcodes, bus-source and ALU
//            operation codes, and the internal control-word struct.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'd0,
    ST_F0     = 5'd1,
    ST_F1     = 5'd2,
    ST_F2     = 5'd3,
    ST_F3     = 5'd4,
    ST_DEC    = 5'd5,
    ST_R3     = 5'd6,
    ST_R4     = 5'd7,
    ST_R5     = 5'd8,
    ST_I3     = 5'd9,
    ST_I4     = 5'd10,
    ST_I5     = 5'd11,
    ST_B3     = 5'd12,
    ST_B4     = 5'd13,
    ST_B5     = 5'd14,
    ST_B6     = 5'd15,
    ST_J3     = 5'd16,
    ST_L3     = 5'd17,
    ST_L4     = 5'd18,
    ST_HALTED = 5'd19
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] BSEL_NONE = 5'b00000;
  localparam logic [4:0] BSEL_C    = 5'b01100;
  localparam logic [4:0] BSEL_ZLO  = 5'b10011;
  localparam logic [4:0] BSEL_PC   = 5'b10100;
  localparam logic [4:0] BSEL_MDR  = 5'b10101;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;

  // Only the controls this block can actually assert; the permanently-zero
  // datapath enables are tied off at the top level.
  typedef struct packed {
    logic       incPC;
    logic       e_PC;
    logic       e_IR;
    logic       e_Y;
    logic       e_Z;
    logic       e_MDR;
    logic       e_MAR;
    logic       e_RA;
    logic       e_CON_FF;
    logic       ram_read;
    logic       MDR_read;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       e_Rin;
    logic       e_Rout;
    logic       imm_sel;
    logic [3:0] alu_op;
    logic [4:0] bus_sel;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_of = ALU_ADD;
      OP_SUB:          alu_of = ALU_SUB;
      OP_AND, OP_ANDI: alu_of = ALU_AND;
      OP_OR,  OP_ORI:  alu_of = ALU_OR;
      default:         alu_of = ALU_NONE;
    endcase
  endfunction

  function automatic logic op_is_ralu(input logic [4:0] op);
    op_is_ralu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic op_is_ialu(input logic [4:0] op);
    op_is_ialu = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic op_is_mapped(input logic [4:0] op);
    op_is_mapped = op_is_ralu(op) || op_is_ialu(op) || (op == OP_BR) || (op == OP_JR) ||
                   (op == OP_JAL) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_decode
// Purpose  : Purely combinational map from sequencer state, opcode and CON FF
//            to the controller's control word.
// Ports    : i_state  - current sequencer state
//            i_opcode - ir[31:27]
//            i_con_ff - branch condition flag from the datapath
//            o_ctrl   - decoded control word
// Revision : 1.0 - initial release
// ============================================================================
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [4:0] i_opcode,
  input  logic       i_con_ff,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl         = '0;
    o_ctrl.bus_sel = BSEL_NONE;
    o_ctrl.alu_op  = ALU_NONE;
    case (i_state)
      ST_F0: begin
        o_ctrl.bus_sel = BSEL_PC;
        o_ctrl.e_MAR   = 1'b1;
        o_ctrl.incPC   = 1'b1;
      end
      ST_F1: o_ctrl.ram_read = 1'b1;
      ST_F2: begin
        o_ctrl.MDR_read = 1'b1;
        o_ctrl.e_MDR    = 1'b1;
      end
      ST_F3: begin
        o_ctrl.bus_sel = BSEL_MDR;
        o_ctrl.e_IR    = 1'b1;
      end
      ST_DEC: o_ctrl.illegal = !op_is_mapped(i_opcode);
      ST_R3, ST_I3: begin
        o_ctrl.Grb    = 1'b1;
        o_ctrl.e_Rout = 1'b1;
        o_ctrl.e_Y    = 1'b1;
      end
      ST_R4: begin
        o_ctrl.Grc    = 1'b1;
        o_ctrl.e_Rout = 1'b1;
        o_ctrl.e_Z    = 1'b1;
        o_ctrl.alu_op = alu_of(i_opcode);
      end
      ST_I4: begin
        o_ctrl.bus_sel = BSEL_C;
        o_ctrl.imm_sel = 1'b1;
        o_ctrl.e_Z     = 1'b1;
        o_ctrl.alu_op  = alu_of(i_opcode);
      end
      ST_R5, ST_I5: begin
        o_ctrl.bus_sel = BSEL_ZLO;
        o_ctrl.Gra     = 1'b1;
        o_ctrl.e_Rin   = 1'b1;
      end
      ST_B3: begin
        o_ctrl.Gra      = 1'b1;
        o_ctrl.e_Rout   = 1'b1;
        o_ctrl.e_CON_FF = 1'b1;
      end
      ST_B4: begin
        o_ctrl.bus_sel = BSEL_PC;
        o_ctrl.e_Y     = 1'b1;
      end
      ST_B5: begin
        o_ctrl.bus_sel = BSEL_C;
        o_ctrl.imm_sel = 1'b1;
        o_ctrl.alu_op  = ALU_ADD;
        o_ctrl.e_Z     = 1'b1;
      end
      // The target is always on the bus; CON FF decides whether PC takes it.
      ST_B6: begin
        o_ctrl.bus_sel = BSEL_ZLO;
        o_ctrl.e_PC    = i_con_ff;
      end
      ST_J3, ST_L4: begin
        o_ctrl.Gra    = 1'b1;
        o_ctrl.e_Rout = 1'b1;
        o_ctrl.e_PC   = 1'b1;
      end
      ST_L3: begin
        o_ctrl.bus_sel = BSEL_PC;
        o_ctrl.e_RA    = 1'b1;
      end
      ST_HALTED: o_ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Hardwired sequencer for the Mini SRC datapath. Holds the state
//            register and next-state logic; control outputs come from
//            control_decode.
// Ports    : clock, clear (async active-low), run, ir[31:0], con_ff in;
//            datapath enables, ALU_op[3:0], BusDataSelect[4:0], halted and
//            illegal out.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        incPC,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        e_OutPort,
  output logic        e_InPort,
  output logic        e_RA,
  output logic        e_CON_FF,
  output logic        ram_read,
  output logic        ram_write,
  output logic        MDR_read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        e_Rin,
  output logic        e_Rout,
  output logic        BAout,
  output logic        imm_sel,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic        halted,
  output logic        illegal
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_after;
  logic [4:0] w_opcode;
  ctrl_t      w_ctrl;
  logic       w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // End of every execute sequence: run is sampled only here, so dropping it
  // mid-instruction lets the instruction finish.
  assign w_after = run ? ST_F0 : ST_IDLE;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_F0;
      ST_F0:   w_next = ST_F1;
      ST_F1:   w_next = ST_F2;
      ST_F2:   w_next = ST_F3;
      ST_F3:   w_next = ST_DEC;
      ST_DEC: begin
        if (op_is_ralu(w_opcode))      w_next = ST_R3;
        else if (op_is_ialu(w_opcode)) w_next = ST_I3;
        else if (w_opcode == OP_BR)    w_next = ST_B3;
        else if (w_opcode == OP_JR)    w_next = ST_J3;
        else if (w_opcode == OP_JAL)   w_next = ST_L3;
        else if (w_opcode == OP_HALT)  w_next = ST_HALTED;
        else                           w_next = w_after;
      end
      ST_R3:     w_next = ST_R4;
      ST_R4:     w_next = ST_R5;
      ST_R5:     w_next = w_after;
      ST_I3:     w_next = ST_I4;
      ST_I4:     w_next = ST_I5;
      ST_I5:     w_next = w_after;
      ST_B3:     w_next = ST_B4;
      ST_B4:     w_next = ST_B5;
      ST_B5:     w_next = ST_B6;
      ST_B6:     w_next = w_after;
      ST_J3:     w_next = w_after;
      ST_L3:     w_next = ST_L4;
      ST_L4:     w_next = w_after;
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_IDLE;
    endcase
  end

  control_decode u_decode (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_con_ff (con_ff),
    .o_ctrl   (w_ctrl)
  );

  assign incPC         = w_ctrl.incPC;
  assign e_PC          = w_ctrl.e_PC;
  assign e_IR          = w_ctrl.e_IR;
  assign e_Y           = w_ctrl.e_Y;
  assign e_Z           = w_ctrl.e_Z;
  assign e_MDR         = w_ctrl.e_MDR;
  assign e_MAR         = w_ctrl.e_MAR;
  assign e_RA          = w_ctrl.e_RA;
  assign e_CON_FF      = w_ctrl.e_CON_FF;
  assign ram_read      = w_ctrl.ram_read;
  assign MDR_read      = w_ctrl.MDR_read;
  assign Gra           = w_ctrl.Gra;
  assign Grb           = w_ctrl.Grb;
  assign Grc           = w_ctrl.Grc;
  assign e_Rin         = w_ctrl.e_Rin;
  assign e_Rout        = w_ctrl.e_Rout;
  assign imm_sel       = w_ctrl.imm_sel;
  assign ALU_op        = w_ctrl.alu_op;
  assign BusDataSelect = w_ctrl.bus_sel;
  assign halted        = w_ctrl.halted;
  assign illegal       = w_ctrl.illegal;

  assign e_HI      = 1'b0;
  assign e_LO      = 1'b0;
  assign e_GP      = 1'b0;
  assign e_OutPort = 1'b0;
  assign e_InPort  = 1'b0;
  assign ram_write = 1'b0;
  assign BAout     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Self-checking bench for control_unit. A small behavioural
//            datapath obeys the controller's outputs; an instruction-level
//            reference model predicts the per-cycle control sequence and the
//            architectural results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  localparam logic [4:0] C_ADD = 5'b00011, C_SUB = 5'b00100, C_AND = 5'b00101, C_OR = 5'b00110;
  localparam logic [4:0] C_ADDI = 5'b01100, C_ANDI = 5'b01101, C_ORI = 5'b01110;
  localparam logic [4:0] C_BR = 5'b10010, C_JR = 5'b10100, C_JAL = 5'b10101;
  localparam logic [4:0] C_NOP = 5'b11010, C_HALT = 5'b11011;

  typedef struct packed {
    logic incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, e_OutPort, e_InPort;
    logic e_RA, e_CON_FF, ram_read, ram_write, MDR_read, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
    logic [3:0] alu;
    logic [4:0] bsel;
    logic halted, illegal;
  } tctl_t;

  logic clock = 1'b0;
  logic clear, run, con_ff;
  logic [31:0] ir;
  logic incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, e_OutPort, e_InPort;
  logic e_RA, e_CON_FF, ram_read, ram_write, MDR_read, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
  logic [3:0] ALU_op;
  logic [4:0] BusDataSelect;
  logic halted, illegal;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .con_ff(con_ff),
    .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
    .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .e_OutPort(e_OutPort), .e_InPort(e_InPort),
    .e_RA(e_RA), .e_CON_FF(e_CON_FF), .ram_read(ram_read), .ram_write(ram_write),
    .MDR_read(MDR_read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout),
    .BAout(BAout), .imm_sel(imm_sel), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
    .halted(halted), .illegal(illegal)
  );

  tctl_t obs;
  assign obs = {incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, e_OutPort, e_InPort,
                e_RA, e_CON_FF, ram_read, ram_write, MDR_read, Gra, Grb, Grc, e_Rin, e_Rout, BAout,
                imm_sel, ALU_op, BusDataSelect, halted, illegal};

  // ---------------- helpers shared by datapath and reference ---------------
  function automatic logic cond_of(input logic [1:0] c2, input logic [31:0] v);
    case (c2)
      2'b00:   cond_of = (v == 32'd0);
      2'b01:   cond_of = (v != 32'd0);
      2'b10:   cond_of = !v[31];
      default: cond_of = v[31];
    endcase
  endfunction

  function automatic logic [31:0] sext19(input logic [18:0] c);
    sext19 = {{13{c[18]}}, c};
  endfunction

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0011: alu_f = a + b;
      4'b0100: alu_f = a - b;
      4'b0101: alu_f = a & b;
      4'b0110: alu_f = a | b;
      default: alu_f = 32'd0;
    endcase
  endfunction

  // ---------------- behavioural datapath driven by the DUT -----------------
  logic [31:0] mem [256];
  logic [31:0] dp_r [16] = '{default: 32'd0};
  logic [31:0] dp_pc = 32'd0, dp_mar = 32'd0, dp_mdr = 32'd0, dp_ir = 32'd0;
  logic [31:0] dp_y = 32'd0, dp_z = 32'd0;
  logic        dp_con = 1'b0;
  logic [31:0] bus;
  logic [3:0]  sel;
  logic        pk_en = 1'b0, pk_pc = 1'b0;
  logic [3:0]  pk_idx = 4'd0;
  logic [31:0] pk_val = 32'd0;

  assign ir     = dp_ir;
  assign con_ff = dp_con;

  always_comb begin
    sel = dp_ir[18:15];
    if (Gra)      sel = dp_ir[26:23];
    else if (Grb) sel = dp_ir[22:19];
  end

  always_comb begin
    bus = 32'd0;
    if (e_Rout) bus = dp_r[sel];
    else begin
      case (BusDataSelect)
        5'b10100: bus = dp_pc;
        5'b10101: bus = dp_mdr;
        5'b10011: bus = dp_z;
        5'b01100: bus = sext19(dp_ir[18:0]);
        default:  bus = 32'd0;
      endcase
    end
  end

  always @(posedge clock) begin
    if (pk_en) begin
      if (pk_pc) dp_pc <= pk_val;
      else       dp_r[pk_idx] <= pk_val;
    end else begin
      if (incPC)              dp_pc  <= dp_pc + 32'd1;
      if (e_PC)               dp_pc  <= bus;
      if (e_MAR)              dp_mar <= bus;
      if (MDR_read && e_MDR)  dp_mdr <= mem[dp_mar[7:0]];
      if (e_IR)               dp_ir  <= bus;
      if (e_Y)                dp_y   <= bus;
      if (e_Z)                dp_z   <= alu_f(ALU_op, dp_y, bus);
      if (e_Rin)              dp_r[sel] <= bus;
      if (e_RA)               dp_r[15]  <= bus;
      if (e_CON_FF)           dp_con <= cond_of(dp_ir[20:19], bus);
    end
  end

  // ---------------- reference model and checking ---------------------------
  logic [31:0] ref_r [16] = '{default: 32'd0};
  logic [31:0] ref_pc = 32'd0;
  tctl_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk_ctl(input string tag, input tctl_t o, input tctl_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Expected control words of one instruction, from F0 through its last step.
  task automatic build_exp(input logic [4:0] op, input logic taken);
    tctl_t s;
    logic [3:0] a;
    exp_q.delete();
    case (op)
      C_ADD, C_ADDI: a = 4'b0011;
      C_SUB:         a = 4'b0100;
      C_AND, C_ANDI: a = 4'b0101;
      C_OR, C_ORI:   a = 4'b0110;
      default:       a = 4'b0000;
    endcase
    s = '0; s.bsel = 5'b10100; s.e_MAR = 1; s.incPC = 1; exp_q.push_back(s);
    s = '0; s.ram_read = 1; exp_q.push_back(s);
    s = '0; s.MDR_read = 1; s.e_MDR = 1; exp_q.push_back(s);
    s = '0; s.bsel = 5'b10101; s.e_IR = 1; exp_q.push_back(s);
    s = '0;
    s.illegal = !(op inside {C_ADD, C_SUB, C_AND, C_OR, C_ADDI, C_ANDI, C_ORI, C_BR, C_JR, C_JAL, C_NOP, C_HALT});
    exp_q.push_back(s);
    if (op inside {C_ADD, C_SUB, C_AND, C_OR, C_ADDI, C_ANDI, C_ORI}) begin
      s = '0; s.Grb = 1; s.e_Rout = 1; s.e_Y = 1; exp_q.push_back(s);
      s = '0; s.e_Z = 1; s.alu = a;
      if (op inside {C_ADDI, C_ANDI, C_ORI}) begin s.bsel = 5'b01100; s.imm_sel = 1; end
      else begin s.Grc = 1; s.e_Rout = 1; end
      exp_q.push_back(s);
      s = '0; s.bsel = 5'b10011; s.Gra = 1; s.e_Rin = 1; exp_q.push_back(s);
    end else if (op == C_BR) begin
      s = '0; s.Gra = 1; s.e_Rout = 1; s.e_CON_FF = 1; exp_q.push_back(s);
      s = '0; s.bsel = 5'b10100; s.e_Y = 1; exp_q.push_back(s);
      s = '0; s.bsel = 5'b01100; s.imm_sel = 1; s.alu = 4'b0011; s.e_Z = 1; exp_q.push_back(s);
      s = '0; s.bsel = 5'b10011; s.e_PC = taken; exp_q.push_back(s);
    end else if (op == C_JR) begin
      s = '0; s.Gra = 1; s.e_Rout = 1; s.e_PC = 1; exp_q.push_back(s);
    end else if (op == C_JAL) begin
      s = '0; s.bsel = 5'b10100; s.e_RA = 1; exp_q.push_back(s);
      s = '0; s.Gra = 1; s.e_Rout = 1; s.e_PC = 1; exp_q.push_back(s);
    end else if (op == C_HALT) begin
      s = '0; s.halted = 1;
      for (int k = 0; k < 22; k++) exp_q.push_back(s);
    end
  endtask

  task automatic ref_exec(input logic [31:0] instr);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [31:0] c, pc1;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    c = sext19(instr[18:0]);
    pc1 = ref_pc + 32'd1;
    ref_pc = pc1;
    case (op)
      C_ADD:  ref_r[ra] = ref_r[rb] + ref_r[rc];
      C_SUB:  ref_r[ra] = ref_r[rb] - ref_r[rc];
      C_AND:  ref_r[ra] = ref_r[rb] & ref_r[rc];
      C_OR:   ref_r[ra] = ref_r[rb] | ref_r[rc];
      C_ADDI: ref_r[ra] = ref_r[rb] + c;
      C_ANDI: ref_r[ra] = ref_r[rb] & c;
      C_ORI:  ref_r[ra] = ref_r[rb] | c;
      C_BR:   if (cond_of(instr[20:19], ref_r[ra])) ref_pc = pc1 + c;
      C_JR:   ref_pc = ref_r[ra];
      C_JAL:  begin ref_r[15] = pc1; ref_pc = ref_r[ra]; end
      default: ;
    endcase
  endtask

  task automatic chk_regs(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 16; k++) if (dp_r[k] !== ref_r[k]) bad++;
    checks++;
    assert (bad == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d differing registers expected 0", tag, bad);
    end
  endtask

  // Called at a negedge in IDLE.
  task automatic poke(input logic is_pc, input logic [3:0] idx, input logic [31:0] val);
    pk_en = 1'b1; pk_pc = is_pc; pk_idx = idx; pk_val = val;
    if (is_pc) ref_pc = val; else ref_r[idx] = val;
    @(posedge clock); @(negedge clock);
    pk_en = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of F0.
  task automatic start();
    chk_ctl("idle_zero", obs, '0);
    run = 1'b1;
    @(posedge clock); @(negedge clock);
  endtask

  // Called at the negedge of F0. drop_idx: step at which run takes run_after
  // (-1 = last step). abort_idx: step at which clear is pulsed (-1 = none).
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic run_after,
                           input int drop_idx, input int abort_idx);
    logic [4:0] op;
    logic       taken;
    int         n, di;
    op = instr[31:27];
    mem[ref_pc[7:0]] = instr;
    taken = cond_of(instr[20:19], ref_r[instr[26:23]]);
    build_exp(op, taken);
    n = exp_q.size();
    di = (drop_idx < 0) ? n - 1 : drop_idx;
    for (int i = 0; i < n; i++) begin
      if (i == abort_idx) begin
        clear = 1'b0;
        #1;
        chk_ctl({tag, "_abort_async"}, obs, '0);
        run = 1'b0;
        @(posedge clock); @(negedge clock);
        chk_ctl({tag, "_abort_held"}, obs, '0);
        ref_pc = ref_pc + 32'd1;
        chk_regs({tag, "_abort_regs"});
        chk32({tag, "_abort_pc"}, dp_pc, ref_pc);
        clear = 1'b1;
        @(negedge clock);
        return;
      end
      chk_ctl($sformatf("%s_step%0d", tag, i), obs, exp_q[i]);
      if (i == di) run = run_after;
      @(posedge clock); @(negedge clock);
    end
    ref_exec(instr);
    chk32({tag, "_pc"}, dp_pc, ref_pc);
    chk_regs({tag, "_regs"});
    if (!run_after) chk_ctl({tag, "_to_idle"}, obs, '0);
  endtask

  initial begin
    logic [4:0]  ops [11];
    logic [4:0]  op;
    logic [31:0] instr;
    logic        ra_run;
    ops = '{C_ADD, C_SUB, C_AND, C_OR, C_ADDI, C_ANDI, C_ORI, C_BR, C_JR, C_JAL, C_NOP};
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    clear = 1'b0;
    run   = 1'b0;
    #1;
    chk_ctl("reset_zero", obs, '0);
    repeat (3) @(negedge clock);
    chk_ctl("reset_held", obs, '0);
    clear = 1'b1;
    @(negedge clock);

    // R-ALU: R3 = R1 + R2 = 12
    poke(1'b0, 4'd1, 32'd5);
    poke(1'b0, 4'd2, 32'd7);
    poke(1'b1, 4'd0, 32'd0);
    start();
    run_instr("add", {C_ADD, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b0, -1, -1);
    chk32("add_r3", dp_r[3], 32'd12);

    // Branch taken (brpl, R1 positive) and not taken (R1 negative)
    poke(1'b0, 4'd1, 32'h0000_0010);
    poke(1'b1, 4'd0, 32'd4);
    start();
    run_instr("br_taken", {C_BR, 4'd1, 2'b00, 2'b10, 19'd35}, 1'b0, -1, -1);
    chk32("br_taken_pc", dp_pc, 32'd40);
    poke(1'b0, 4'd1, 32'h8000_0000);
    poke(1'b1, 4'd0, 32'd4);
    poke(1'b0, 4'd4, 32'h20);
    start();
    run_instr("br_not", {C_BR, 4'd1, 2'b00, 2'b10, 19'd35}, 1'b1, -1, -1);
    chk32("br_not_pc", dp_pc, 32'd5);

    // jal through R4 then jr back through the link register
    run_instr("jal", {C_JAL, 4'd4, 23'd0}, 1'b1, -1, -1);
    chk32("jal_pc", dp_pc, 32'h20);
    run_instr("jr", {C_JR, 4'd15, 23'd0}, 1'b1, -1, -1);
    chk32("jr_pc", dp_pc, 32'd6);

    // Unmapped opcode, then I-ALU with run dropped in I3
    run_instr("illegal", {5'b11111, 27'd0}, 1'b1, -1, -1);
    run_instr("addi_stop", {C_ADDI, 4'd6, 4'd1, 19'h7FFFD}, 1'b0, 5, -1);

    // Clear asserted during R4 of an ADD
    start();
    run_instr("add_abort", {C_ADD, 4'd3, 4'd6, 4'd2, 15'd0}, 1'b1, -1, 6);
    chk32("abort_r3", dp_r[3], 32'd12);

    // Halt, then leave it with clear
    start();
    run_instr("halt", {C_HALT, 27'd0}, 1'b1, -1, -1);
    clear = 1'b0;
    run = 1'b0;
    #1;
    chk_ctl("halt_clear", obs, '0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);

    // Randomized instruction stream
    for (int k = 0; k < 16; k++)
      poke(1'b0, 4'(k), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
    start();
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 11) == 0) begin
        do op = 5'($urandom_range(0, 31));
        while (op inside {C_ADD, C_SUB, C_AND, C_OR, C_ADDI, C_ANDI, C_ORI, C_BR, C_JR, C_JAL, C_NOP, C_HALT});
      end else begin
        op = ops[$urandom_range(0, 10)];
      end
      instr = {op, 27'($urandom)};
      if (op == C_JAL) instr[26:23] = 4'($urandom_range(0, 14));
      ra_run = ($urandom_range(0, 4) != 0);
      run_instr($sformatf("rnd%0d", t), instr, ra_run, -1, -1);
      if (!ra_run) start();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
